// File: rtl/tanh_backward.sv
// tanh_backward: buffers forward tanh outputs y (Q8.8) in an activation FIFO,
// then for each upstream gradient g produces dL/dx = g * (1 - y^2) through a
// three-stage arithmetic pipeline. Valid/ready on every stream, global stall.
module tanh_backward #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [DATA_WIDTH-1:0]         act_in,
  input  logic                          act_valid,
  output logic                          act_ready,
  input  logic [DATA_WIDTH-1:0]         grad_in,
  input  logic                          grad_valid,
  output logic                          grad_ready,
  output logic [DATA_WIDTH-1:0]         grad_out,
  output logic                          grad_out_valid,
  input  logic                          grad_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   act_count,
  output logic                          err_overflow
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int OM_W = FRAC_BITS + 1;
  localparam int SQ_W = 2 * DATA_WIDTH;
  localparam int P_W  = DATA_WIDTH + OM_W + 1;

  localparam logic [AW:0]                   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [OM_W-1:0]               ONE_C   = OM_W'(1 << FRAC_BITS);
  localparam logic signed [DATA_WIDTH-1:0]  Y_HI    = DATA_WIDTH'(1 << FRAC_BITS);
  localparam logic signed [DATA_WIDTH-1:0]  Y_LO    = DATA_WIDTH'(-(1 << FRAC_BITS));
  localparam logic signed [P_W-1:0]         HALF_C  = P_W'(1 << (FRAC_BITS - 1));
  localparam logic signed [P_W-1:0]         SAT_HI  = P_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [P_W-1:0]         SAT_LO  = P_W'(-(1 << (DATA_WIDTH - 1)));

  // Limit y to [-1.0, +1.0] so that 1 - y^2 stays non-negative.
  function automatic logic signed [DATA_WIDTH-1:0] clamp_y(input logic signed [DATA_WIDTH-1:0] y);
    if (y > Y_HI) return Y_HI;
    if (y < Y_LO) return Y_LO;
    return y;
  endfunction

  // Round half up by adding 0.5 LSB before the arithmetic shift, then saturate.
  function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] r;
    r = (p + HALF_C) >>> FRAC_BITS;
    if (r > SAT_HI)      r = SAT_HI;
    else if (r < SAT_LO) r = SAT_LO;
    return DATA_WIDTH'(r);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  err_q, err_d;
  logic                  full, empty, advance, push, pop;

  logic                          vld_p0, vld_p1, vld_p2;
  logic signed [DATA_WIDTH-1:0]  y_p0, g_p0, g_p1, grad_out_p2;
  logic        [OM_W-1:0]        om_p1;
  logic signed [SQ_W-1:0]        sq_c;
  logic        [OM_W-1:0]        ysq_c;
  logic signed [P_W-1:0]         prod_c;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign advance = !vld_p2 || grad_out_ready;
  assign push    = act_valid && !full;
  assign pop     = grad_valid && grad_ready;

  assign act_ready      = !full;
  assign grad_ready     = !empty && advance;
  assign act_count      = count_q;
  assign err_overflow   = err_q;
  assign grad_out       = grad_out_p2;
  assign grad_out_valid = vld_p2;

  // FIFO pointer, occupancy and overflow-flag next state; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
      if (act_valid && full) err_d = 1'b1;
    end
  end

  // FIFO control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Activation storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= act_in;
  end

  // Stage valids shift together only when the pipeline advances.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= pop;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  assign sq_c   = SQ_W'(y_p0) * SQ_W'(y_p0);
  assign ysq_c  = OM_W'(sq_c >>> FRAC_BITS);
  assign prod_c = P_W'(g_p1) * $signed(P_W'(om_p1));

  // Stage 1 / stage 2 datapath: capture clamped y and g, then form 1 - y^2.
  always_ff @(posedge clk) begin
    if (advance) begin
      // ---- stage 1: FIFO head and gradient
      y_p0  <= clamp_y($signed(mem_q[rd_ptr_q]));
      g_p0  <= $signed(grad_in);
      // ---- stage 2: one-minus-square
      om_p1 <= ONE_C - ysq_c;
      g_p1  <= g_p0;
    end
  end

  // Stage 3: product, rounding and saturation into the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      grad_out_p2 <= '0;
    end else if (advance) begin
      grad_out_p2 <= round_sat(prod_c);
    end
  end
endmodule
